// File: rtl/serial_frame_deser_pkg.sv
// Shared types and default parameters for the serial frame receiver.
package serial_frame_deser_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam logic [7:0]  DEF_SYNC        = 8'hA5;
  localparam int unsigned DEF_FRAME_WORDS = 4;

endpackage

// File: rtl/deser_out_reg.sv
// One-word valid/ready holding register; words arriving while it is full are
// dropped and reported with a registered one-cycle overrun pulse.
module deser_out_reg
  import serial_frame_deser_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_load,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (word_load) begin
        // An accept on the same edge frees the slot, so the new word loads with no bubble.
        if (!dout_valid || dout_ready) begin
          dout       <= word_in;
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_frame_deser.sv
// Serial-to-parallel frame receiver: bit-aligned sync hunt, then FRAME_WORDS
// MSB-first words of WIDTH bits handed to a one-word output register.
module serial_frame_deser
  import serial_frame_deser_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SYNC        = WIDTH'(DEF_SYNC),
  parameter int unsigned      FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clken,
  input  logic             si,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             in_frame,
  output logic             overrun
);

  localparam int unsigned BW = $clog2(WIDTH);

  if (SYNC == '0) begin : g_bad_sync
    $error("serial_frame_deser: SYNC must be nonzero");
  end
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("serial_frame_deser: WIDTH must be 2..32");
  end
  if (FRAME_WORDS < 1 || FRAME_WORDS > 255) begin : g_bad_words
    $error("serial_frame_deser: FRAME_WORDS must be 1..255");
  end

  state_t           state, state_n;
  // Only the WIDTH-1 newest bits are stored; the incoming bit completes the window.
  logic [WIDTH-2:0] hist, hist_n;
  logic [WIDTH-2:0] shift, shift_n;
  logic [BW-1:0]    bcnt, bcnt_n;
  logic [7:0]       wcnt, wcnt_n;
  logic [WIDTH-1:0] hist_win;
  logic [WIDTH-1:0] word;
  logic             word_load;

  assign hist_win = {hist, si};
  assign word     = {shift, si};
  assign in_frame = (state == DATA);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HUNT;
      hist  <= '0;
      shift <= '0;
      bcnt  <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      hist  <= hist_n;
      shift <= shift_n;
      bcnt  <= bcnt_n;
      wcnt  <= wcnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    hist_n    = hist;
    shift_n   = shift;
    bcnt_n    = bcnt;
    wcnt_n    = wcnt;
    word_load = 1'b0;
    if (clken) begin
      unique case (state)
        HUNT: begin
          hist_n = hist_win[WIDTH-2:0];
          if (hist_win == SYNC) begin
            state_n = DATA;
            bcnt_n  = '0;
            wcnt_n  = '0;
          end
        end
        DATA: begin
          shift_n = word[WIDTH-2:0];
          if (bcnt == BW'(WIDTH - 1)) begin
            word_load = 1'b1;
            bcnt_n    = '0;
            wcnt_n    = wcnt + 8'd1;
            // Frame bits never feed the sync search, so the history restarts empty.
            if (wcnt == 8'(FRAME_WORDS - 1)) begin
              state_n = HUNT;
              hist_n  = '0;
            end
          end else begin
            bcnt_n = bcnt + BW'(1);
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  deser_out_reg #(
    .WIDTH(WIDTH)
  ) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .word_in   (word),
    .word_load (word_load),
    .dout_ready(dout_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .overrun   (overrun)
  );

endmodule
